// File: rtl/axis_extract_header_if.sv
// Bundle for axi_stream_extract_header: input stream, header length, payload stream,
// header channel and short-packet flag. Optional `bypass` exists when AXIS_EXTRACT_HEADER_BYPASS_EN is defined.
interface axis_extract_header_if #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8
);
    localparam int HL_W = $clog2(DATA_BYTE_WD) + 1;

    logic                    valid_in;
    logic [DATA_WD-1:0]      data_in;
    logic [DATA_BYTE_WD-1:0] keep_in;
    logic                    last_in;
    logic                    ready_in;
    logic [HL_W-1:0]         header_len;
`ifdef AXIS_EXTRACT_HEADER_BYPASS_EN
    logic                    bypass;
`endif
    logic                    valid_out;
    logic [DATA_WD-1:0]      data_out;
    logic [DATA_BYTE_WD-1:0] keep_out;
    logic                    last_out;
    logic                    ready_out;
    logic                    valid_header;
    logic [DATA_WD-1:0]      header_out;
    logic [DATA_BYTE_WD-1:0] keep_header;
    logic                    ready_header;
    logic                    err_short;

    modport slave (
        input  `ifdef AXIS_EXTRACT_HEADER_BYPASS_EN bypass, `endif
               valid_in, data_in, keep_in, last_in, header_len, ready_out, ready_header,
        output ready_in, valid_out, data_out, keep_out, last_out,
               valid_header, header_out, keep_header, err_short
    );

    modport master (
        output `ifdef AXIS_EXTRACT_HEADER_BYPASS_EN bypass, `endif
               valid_in, data_in, keep_in, last_in, header_len, ready_out, ready_header,
        input  ready_in, valid_out, data_out, keep_out, last_out,
               valid_header, header_out, keep_header, err_short
    );
endinterface

// File: rtl/axi_stream_extract_header.sv
// Strips a 1..DATA_BYTE_WD byte header from the first beat of each packet and re-packs the payload MSB-first.
// Define AXIS_EXTRACT_HEADER_BYPASS_EN to add a per-packet `bypass` that forwards packets untouched.
module axi_stream_extract_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    axis_extract_header_if.slave  axis
);
    localparam int W     = DATA_BYTE_WD;
    localparam int CNT_W = $clog2(W) + 2;

    typedef logic [CNT_W-1:0]   cnt_t;
    typedef logic [DATA_WD-1:0] word_t;
    typedef logic [W-1:0]       keep_t;
    typedef enum logic [1:0] {S_HDR, S_BODY, S_FLUSH} state_t;

    localparam cnt_t W_C = cnt_t'(W);

    function automatic keep_t msb_mask(input cnt_t n);
        keep_t ones;
        ones = '1;
        return ~(ones >> n);
    endfunction

    function automatic keep_t lsb_mask(input cnt_t n);
        keep_t ones;
        ones = '1;
        return ~(ones << n);
    endfunction

    function automatic logic [CNT_W+2:0] byte_sh(input cnt_t n);
        return {n, 3'b000};
    endfunction

    function automatic word_t apply_keep(input word_t d, input keep_t k);
        word_t o;
        o = '0;
        for (int i = 0; i < W; i++) o[8*i +: 8] = d[8*i +: 8] & {8{k[i]}};
        return o;
    endfunction

    state_t state, state_nxt;
    word_t  resid;
    cnt_t   r_cnt, r_nxt, f_cnt, f_nxt;
    logic   byp_q, byp_nxt, byp_first;
    cnt_t   k_cnt, n_len, r_len;
    logic   rdy, acc, out_free;
    logic   ld_out, nd_last, ld_hdr, ld_res, short_nxt;
    word_t  nd_data, nh_data;
    keep_t  nd_keep, nh_keep;

`ifdef AXIS_EXTRACT_HEADER_BYPASS_EN
    assign byp_first = axis.bypass;
`else
    assign byp_first = 1'b0;
`endif

    always_comb begin
        k_cnt = '0;
        for (int i = 0; i < W; i++) k_cnt = k_cnt + cnt_t'(axis.keep_in[i]);
    end

    // Out-of-range header lengths collapse to a full-beat header.
    assign n_len = (axis.header_len == '0 || cnt_t'(axis.header_len) > W_C) ? W_C : cnt_t'(axis.header_len);
    assign r_len = W_C - n_len;
    assign axis.ready_in = rdy;

    always_comb begin
        state_nxt = state;
        rdy       = 1'b0;
        ld_out    = 1'b0;
        nd_data   = '0;
        nd_keep   = '0;
        nd_last   = 1'b0;
        ld_hdr    = 1'b0;
        nh_data   = '0;
        nh_keep   = '0;
        ld_res    = 1'b0;
        short_nxt = 1'b0;
        r_nxt     = r_cnt;
        f_nxt     = f_cnt;
        byp_nxt   = byp_q;
        out_free  = ~axis.valid_out | axis.ready_out;
        case (state)
            S_HDR:   rdy = (~axis.valid_header | axis.ready_header) & out_free & ~rst;
            S_BODY:  rdy = out_free & ~rst;
            default: rdy = 1'b0;
        endcase
        acc = axis.valid_in & rdy;
        case (state)
            S_HDR: begin
                if (acc) begin
                    ld_res  = 1'b1;
                    r_nxt   = r_len;
                    byp_nxt = byp_first;
                    if (!axis.last_in) state_nxt = S_BODY;
                    if (byp_first) begin
                        ld_out  = 1'b1;
                        nd_data = axis.data_in;
                        nd_keep = axis.keep_in;
                        nd_last = axis.last_in;
                    end else begin
                        ld_hdr = 1'b1;
                        // A short single-beat packet only yields the k bytes actually present.
                        if (axis.last_in && k_cnt < n_len) begin
                            nh_keep   = lsb_mask(k_cnt);
                            nh_data   = apply_keep(axis.data_in >> byte_sh(W_C - k_cnt), nh_keep);
                            short_nxt = 1'b1;
                        end else begin
                            nh_keep = lsb_mask(n_len);
                            nh_data = apply_keep(axis.data_in >> byte_sh(r_len), nh_keep);
                        end
                        if (axis.last_in && k_cnt > n_len) begin
                            ld_out  = 1'b1;
                            nd_keep = msb_mask(k_cnt - n_len);
                            nd_data = apply_keep(axis.data_in << byte_sh(n_len), nd_keep);
                            nd_last = 1'b1;
                        end
                    end
                end
            end
            S_BODY: begin
                if (acc) begin
                    ld_out = 1'b1;
                    ld_res = 1'b1;
                    if (byp_q) begin
                        nd_data = axis.data_in;
                        nd_keep = axis.keep_in;
                        nd_last = axis.last_in;
                        if (axis.last_in) state_nxt = S_HDR;
                    end else begin
                        nd_keep = '1;
                        if (axis.last_in) begin
                            if (r_cnt + k_cnt <= W_C) begin
                                nd_keep   = msb_mask(r_cnt + k_cnt);
                                nd_last   = 1'b1;
                                state_nxt = S_HDR;
                            end else begin
                                f_nxt     = r_cnt + k_cnt - W_C;
                                state_nxt = S_FLUSH;
                            end
                        end
                        nd_data = apply_keep((resid << byte_sh(W_C - r_cnt)) | (axis.data_in >> byte_sh(r_cnt)),
                                             nd_keep);
                    end
                end
            end
            S_FLUSH: begin
                // resid now holds the final input beat; its tail beyond the full beat is the overflow.
                if (out_free) begin
                    ld_out    = 1'b1;
                    nd_keep   = msb_mask(f_cnt);
                    nd_data   = apply_keep(resid << byte_sh(W_C - r_cnt), nd_keep);
                    nd_last   = 1'b1;
                    state_nxt = S_HDR;
                end
            end
            default: state_nxt = S_HDR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_HDR;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resid             <= '0;
            r_cnt             <= '0;
            f_cnt             <= '0;
            byp_q             <= 1'b0;
            axis.err_short    <= 1'b0;
            axis.valid_out    <= 1'b0;
            axis.data_out     <= '0;
            axis.keep_out     <= '0;
            axis.last_out     <= 1'b0;
            axis.valid_header <= 1'b0;
            axis.header_out   <= '0;
            axis.keep_header  <= '0;
        end else begin
            r_cnt          <= r_nxt;
            f_cnt          <= f_nxt;
            byp_q          <= byp_nxt;
            axis.err_short <= short_nxt;
            if (ld_res) resid <= axis.data_in;
            if (ld_out) begin
                axis.valid_out <= 1'b1;
                axis.data_out  <= nd_data;
                axis.keep_out  <= nd_keep;
                axis.last_out  <= nd_last;
            end else if (axis.ready_out) begin
                axis.valid_out <= 1'b0;
                axis.last_out  <= 1'b0;
            end
            if (ld_hdr) begin
                axis.valid_header <= 1'b1;
                axis.header_out   <= nh_data;
                axis.keep_header  <= nh_keep;
            end else if (axis.ready_header) begin
                axis.valid_header <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axi_stream_extract_header.sv
// Directed bench for axi_stream_extract_header: hand-computed header/payload beats for each packet shape.
module tb_axi_stream_extract_header;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tog = 1'b0;
    logic ro_t = 1'b0;
    logic ro_fix = 1'b1;
    int   checks = 0;
    int   fails = 0;
    int   errs = 0;
    logic [63:0] oq[$];
    logic [63:0] hq[$];

    axis_extract_header_if #(.DATA_WD(32)) ifc();

    axi_stream_extract_header #(.DATA_WD(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .axis (ifc)
    );

    always #5 clk = ~clk;

    assign ifc.ready_out = tog ? ro_t : ro_fix;

    always @(posedge clk) begin
        #1;
        if (tog) ro_t = ~ro_t;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (ifc.valid_out && ifc.ready_out)
                oq.push_back({27'd0, ifc.last_out, ifc.keep_out, ifc.data_out});
            if (ifc.valid_header && ifc.ready_header)
                hq.push_back({28'd0, ifc.keep_header, ifc.header_out});
            if (ifc.err_short) errs++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ob(input logic [31:0] d, input logic [3:0] k, input logic l);
        return {27'd0, l, k, d};
    endfunction

    function automatic logic [63:0] hb(input logic [31:0] d, input logic [3:0] k);
        return {28'd0, k, d};
    endfunction

    function automatic logic [63:0] q_at(input int which, input int i);
        if (which == 0) return (i < oq.size()) ? oq[i] : 64'hFFFF_FFFF_FFFF_FFFF;
        return (i < hq.size()) ? hq[i] : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l, input logic [2:0] hl);
        int n;
        ifc.valid_in   = 1'b1;
        ifc.data_in    = d;
        ifc.keep_in    = k;
        ifc.last_in    = l;
        ifc.header_len = hl;
        n = 0;
        @(negedge clk);
        while (!ifc.ready_in && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!ifc.ready_in) chk("accept_timeout", 64'(ifc.ready_in), 64'd1);
        @(posedge clk);
        #1;
        ifc.valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear();
        oq.delete();
        hq.delete();
        errs = 0;
    endtask

    initial begin
        ifc.valid_in     = 1'b0;
        ifc.data_in      = '0;
        ifc.keep_in      = '0;
        ifc.last_in      = 1'b0;
        ifc.header_len   = '0;
        ifc.ready_header = 1'b1;
`ifdef AXIS_EXTRACT_HEADER_BYPASS_EN
        ifc.bypass       = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_ready_in", 64'(ifc.ready_in), 64'd0);
        chk("rst_valid_out", 64'(ifc.valid_out), 64'd0);
        chk("rst_valid_header", 64'(ifc.valid_header), 64'd0);
        chk("rst_data", {ifc.data_out, ifc.header_out}, 64'd0);
        chk("rst_keep", 64'({ifc.keep_out, ifc.keep_header, ifc.last_out, ifc.err_short}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);

        // header_len=2, three beats ending on an exact fit
        clear();
        send(32'hAABB1122, 4'b1111, 1'b0, 3'd2);
        send(32'h33445566, 4'b1111, 1'b0, 3'd2);
        send(32'h77880000, 4'b1100, 1'b1, 3'd2);
        idle(5);
        chk("t1_hdr", q_at(1, 0), hb(32'h0000AABB, 4'b0011));
        chk("t1_d0", q_at(0, 0), ob(32'h11223344, 4'b1111, 1'b0));
        chk("t1_d1", q_at(0, 1), ob(32'h55667788, 4'b1111, 1'b1));
        chk("t1_cnt", 64'(oq.size() + 16 * hq.size()), 64'd18);

        // header_len=1, overflow into FLUSH
        clear();
        send(32'hAA112233, 4'b1111, 1'b0, 3'd1);
        send(32'h44556677, 4'b1110, 1'b1, 3'd1);
        @(negedge clk);
        chk("t2_flush_ready", 64'(ifc.ready_in), 64'd0);
        @(negedge clk);
        chk("t2_hdr_ready", 64'(ifc.ready_in), 64'd1);
        @(posedge clk);
        #1;
        idle(4);
        chk("t2_hdr", q_at(1, 0), hb(32'h000000AA, 4'b0001));
        chk("t2_d0", q_at(0, 0), ob(32'h11223344, 4'b1111, 1'b0));
        chk("t2_d1", q_at(0, 1), ob(32'h55660000, 4'b1100, 1'b1));
        chk("t2_cnt", 64'(oq.size()), 64'd2);

        // single-beat packets: payload left over, then too short for the header
        clear();
        send(32'hAABBCC00, 4'b1110, 1'b1, 3'd2);
        idle(4);
        chk("t3_hdr", q_at(1, 0), hb(32'h0000AABB, 4'b0011));
        chk("t3_d0", q_at(0, 0), ob(32'hCC000000, 4'b1000, 1'b1));
        chk("t3_err0", 64'(errs), 64'd0);
        clear();
        send(32'hAABBCC00, 4'b1000, 1'b1, 3'd2);
        idle(4);
        chk("t3s_hdr", q_at(1, 0), hb(32'h000000AA, 4'b0001));
        chk("t3s_err", 64'(errs), 64'd1);
        chk("t3s_nodata", 64'(oq.size()), 64'd0);

        // header_len=4 pass-through with ready_out toggling
        clear();
        tog = 1'b1;
        send(32'hDEADBEEF, 4'b1111, 1'b0, 3'd4);
        send(32'h01234567, 4'b1111, 1'b0, 3'd4);
        send(32'h89AB0000, 4'b1100, 1'b1, 3'd4);
        idle(8);
        tog = 1'b0;
        idle(2);
        chk("t4_hdr", q_at(1, 0), hb(32'hDEADBEEF, 4'b1111));
        chk("t4_d0", q_at(0, 0), ob(32'h01234567, 4'b1111, 1'b0));
        chk("t4_d1", q_at(0, 1), ob(32'h89AB0000, 4'b1100, 1'b1));
        chk("t4_cnt", 64'(oq.size()), 64'd2);

        // header_len=0 means full beat; a held header blocks HDR acceptance
        clear();
        ifc.ready_header = 1'b0;
        send(32'h12345678, 4'b1111, 1'b1, 3'd0);
        @(negedge clk);
        chk("t4_hold_ready", 64'(ifc.ready_in), 64'd0);
        chk("t4_hold_valid", 64'(ifc.valid_header), 64'd1);
        @(posedge clk);
        #1;
        ifc.ready_header = 1'b1;
        idle(3);
        chk("t4_hl0_hdr", q_at(1, 0), hb(32'h12345678, 4'b1111));
        chk("t4_hl0_nodata", 64'(oq.size()), 64'd0);

        // reset in the middle of a packet
        clear();
        ro_fix = 1'b0;
        ifc.ready_header = 1'b0;
        send(32'h11111111, 4'b1111, 1'b0, 3'd2);
        send(32'h22222222, 4'b1111, 1'b0, 3'd2);
        chk("t5_pre_valid", 64'({ifc.valid_out, ifc.valid_header}), 64'd3);
        rst = 1'b1;
        #1;
        chk("t5_rst_valids", 64'({ifc.valid_out, ifc.valid_header, ifc.ready_in}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ro_fix = 1'b1;
        ifc.ready_header = 1'b1;
        clear();
        idle(1);
        send(32'h01020304, 4'b1111, 1'b0, 3'd3);
        send(32'h05060708, 4'b1111, 1'b1, 3'd3);
        idle(5);
        chk("t5_hdr", q_at(1, 0), hb(32'h00010203, 4'b0111));
        chk("t5_d0", q_at(0, 0), ob(32'h04050607, 4'b1111, 1'b0));
        chk("t5_d1", q_at(0, 1), ob(32'h08000000, 4'b1000, 1'b1));

`ifdef AXIS_EXTRACT_HEADER_BYPASS_EN
        clear();
        ifc.bypass = 1'b1;
        send(32'h12345678, 4'b1111, 1'b0, 3'd2);
        ifc.bypass = 1'b0;
        send(32'h9ABCDEF0, 4'b1100, 1'b1, 3'd2);
        idle(4);
        chk("byp_d0", q_at(0, 0), ob(32'h12345678, 4'b1111, 1'b0));
        chk("byp_d1", q_at(0, 1), ob(32'h9ABCDEF0, 4'b1100, 1'b1));
        chk("byp_nohdr", 64'(hq.size()), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/axi_stream_extract_header.md
# axi_stream_extract_header

- Receive-side counterpart of the header-insert block.
- Strips a leading header of 1..DATA_BYTE_WD bytes from the first beat of each AXI-Stream packet.
- Presents the header on a dedicated header channel and re-packs the remaining payload into dense, MSB-first beats on the data output.
- Sits at the ingress of packet-processing paths, directly downstream of a link receiver.

## Interface
Parameters:
- DATA_WD, 32, data width in bits (multiple of 8)
- DATA_BYTE_WD, DATA_WD/8, bytes per beat

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- valid_in  in  1  input beat valid
- data_in  in  DATA_WD  input data, byte 0 = bits [DATA_WD-1:DATA_WD-8]
- keep_in  in  DATA_BYTE_WD  MSB-first byte mask; all-ones except on last beat
- last_in  in  1  last beat of packet
- ready_in  out  1  input accept
- header_len  in  $clog2(DATA_BYTE_WD)+1  header byte count, sampled on the first accepted beat
- valid_out  out  1  payload beat valid
- data_out  out  DATA_WD  re-packed payload
- keep_out  out  DATA_BYTE_WD  all-ones, or MSB-contiguous (1000/1100/1110/1111) on the last beat
- last_out  out  1  last payload beat
- ready_out  in  1  payload accept
- valid_header  out  1  header valid
- header_out  out  DATA_WD  header bytes, right-aligned in the low bytes
- keep_header  out  DATA_BYTE_WD  right-aligned mask, e.g. 0011 for 2 bytes
- ready_header  in  1  header accept
- err_short  out  1  one-cycle pulse when a first beat holds fewer valid bytes than header_len

## Operation

**Header length**
- N = header_len; values of 0 or greater than DATA_BYTE_WD are treated as DATA_BYTE_WD.

**Residual count**
- R = DATA_BYTE_WD − N bytes carried over in the residual register.

**States**
- HDR: waiting for the first beat of a packet (reset state).
- BODY: packet in progress.
- FLUSH: emitting the final overflow beat.

**HDR, first beat accepted**
- header_out receives the top N bytes of the beat.
- The low R bytes load the residual register.
- Not last: go to BODY.
- Last with valid count k: payload = k − N bytes.
  - If k − N > 0: emit one last_out beat, data MSB-aligned.
  - If k − N ≤ 0: emit no data beat.
  - If k < N: header keep covers only the k bytes present, and err_short pulses.
  - Stay in HDR.

**BODY, beat accepted**
- Output word = residual R bytes followed by the top W−R bytes of the input.
- The residual register takes the low R bytes of the input.
- Last beat with k valid bytes and R+k ≤ W: emit a single last beat with R+k bytes, then go to HDR.
- Last beat with R+k > W: emit a full beat, save the overflow (R+k−W bytes), then go to FLUSH.
- R = 0 is a pure pass-through with keep_out = keep_in.

**FLUSH**
- ready_in = 0.
- Emit an overflow last beat with keep = MSB mask of R+k−W bytes.
- Return to HDR on acceptance.

**Acceptance rules**
- In HDR: ready_in = (~valid_header | ready_header) & (~valid_out | ready_out).
- In BODY: ready_in = (~valid_out | ready_out).

**Stalls and reset**
- Header and data channels are independent registers; a stalled header never blocks payload of the same packet once captured.
- Reset mid-packet discards all state; the next beat after reset is treated as a first beat.

## Timing
- Reset values:
  - ready_in = 0 during reset, combinational after release.
  - valid_out, last_out, valid_header, err_short = 0.
  - data_out, keep_out, header_out, keep_header = 0.
  - State = HDR.
- Latency: valid_header and valid_out assert one cycle after the accepting edge.
- Throughput: one beat per cycle; each FLUSH adds exactly one cycle per packet.
- Output holding:
  - valid_out and its data are held until ready_out is sampled high.
  - valid_header and header data are held likewise until ready_header is sampled high.
- Simultaneous events: the last beat of packet A in BODY and the first beat of packet B can never be accepted in the same cycle. The HDR entry cycle follows.

## Configuration
- AXIS_EXTRACT_HEADER_BYPASS_EN defined:
  - Adds input `bypass` (1 bit), sampled with the first beat.
  - bypass = 1: the packet passes unmodified with 1-cycle latency, no header beat is produced, and err_short is never raised.
- Not defined:
  - Port absent; every packet is stripped.

## Test plan
- header_len=2; beats 0xAABB1122, 0x33445566, last 0x77880000 keep 1100 → header 0x0000AABB keep 0011; data 0x11223344 keep 1111, then 0x55667788 keep 1111 last.
- header_len=1; beats 0xAA112233, last 0x44556677 keep 1110 → header 0x000000AA keep 0001; data 0x11223344, then FLUSH 0x55660000 keep 1100 last; ready_in low for one cycle.
- header_len=2; single beat 0xAABBCC00 keep 1110 last → header 0x0000AABB; data 0xCC000000 keep 1000 last. Same with keep 1000 → header keep 0001, err_short pulses, no data beat.
- header_len=4; 3-beat packet → data identical to beats 2–3 with keep preserved. ready_out toggled 1/0 every cycle → no loss or duplication; ready_header held low → ready_in low in HDR.
- Assert rst mid-BODY → all valids 0 immediately. Then header_len=3 packet 0x01020304, 0x05060708 last → header 0x00010203, data 0x04050607 full, then 0x08000000 keep 1000 last.
- With AXIS_EXTRACT_HEADER_BYPASS_EN and bypass=1 → output beats equal input beats exactly, valid_header stays 0.
